neopix_byte_encoder: RTL and testbench

//  Downstream stage of the SPI byte receiver. Accepts received bytes (8-bit data + 1-cycle valid strobe),

---
 rtl/neopix_pkg.sv | 16 +
 rtl/neopix_fifo.sv | 53 +++++
 rtl/neopix_byte_encoder.sv | 114 +++++++++++
 tb/tb_neopix_byte_encoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared definitions for the NeoPixel byte encoder: FSM state encoding and 50 MHz timing defaults.
package neopix_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam int unsigned T0H_CYC_DEF    = 20;
   localparam int unsigned T1H_CYC_DEF    = 40;
   localparam int unsigned TBIT_CYC_DEF   = 63;
   localparam int unsigned RESET_CYC_DEF  = 3000;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/neopix_fifo.sv
// Single-clock first-word fall-through byte FIFO; dout shows the head entry whenever not empty.
module neopix_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   // A read on the same edge frees the slot, so a write while full is still legal then.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || rd_en);
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/neopix_byte_encoder.sv
// Buffers received bytes and serialises them MSB-first as a WS2812 one-wire waveform,
// followed by a fixed low latch period once the buffer drains.
module neopix_byte_encoder
   import neopix_pkg::*;
#(
   parameter int unsigned T0H_CYC    = T0H_CYC_DEF,
   parameter int unsigned T1H_CYC    = T1H_CYC_DEF,
   parameter int unsigned TBIT_CYC   = TBIT_CYC_DEF,
   parameter int unsigned RESET_CYC  = RESET_CYC_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       dout,
   output logic       busy,
   output logic       overflow,
   output logic       gap_hit
);

   localparam int unsigned CYC_W = $clog2(TBIT_CYC);
   localparam int unsigned GAP_W = $clog2(RESET_CYC);

   state_e           state;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [CYC_W-1:0] hi_len;
   logic [7:0]       fifo_dout;
   logic             fifo_empty;
   logic             fifo_full;
   logic             last_cyc;
   logic             pop;
   logic             wr;

   neopix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (data_valid),
      .din   (data_in),
      .rd_en (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Pop from IDLE, or on the last cycle of the last bit so bytes abut with no gap.
   always_comb begin
      last_cyc = (cyc_cnt == CYC_W'(TBIT_CYC - 1));
      pop      = 1'b0;
      if (!fifo_empty) begin
         pop = (state == IDLE) || ((state == SHIFT) && last_cyc && (bit_cnt == 3'd0));
      end
      wr     = data_valid && (!fifo_full || pop);
      hi_len = shreg[7] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);
   end

   assign busy = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         cyc_cnt  <= '0;
         gap_cnt  <= '0;
         dout     <= 1'b0;
         overflow <= 1'b0;
         gap_hit  <= 1'b0;
      end else begin
         dout <= (state == SHIFT) && (cyc_cnt < hi_len);
         if (data_valid && !wr)      overflow <= 1'b1;
         if (wr && (state == GAP))   gap_hit  <= 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg   <= fifo_dout;
                  bit_cnt <= 3'd7;
                  cyc_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (!last_cyc) begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end else begin
                  cyc_cnt <= '0;
                  if (bit_cnt != 3'd0) begin
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt - 3'd1;
                  end else if (pop) begin
                     shreg   <= fifo_dout;
                     bit_cnt <= 3'd7;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(RESET_CYC - 1)) state   <= IDLE;
               else                                  gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neopix_byte_encoder.sv
// Bench for neopix_byte_encoder: frame-level reference model checked every cycle, plus directed
// waveform measurements against hand-computed pulse widths and latencies.
module tb_neopix_byte_encoder;

   localparam int T0H      = 20;
   localparam int T1H      = 40;
   localparam int TBIT     = 63;
   localparam int RST_CYC  = 3000;
   localparam int DEPTH    = 16;
   localparam int BYTE_CYC = 8 * TBIT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       dout;
   logic       busy;
   logic       overflow;
   logic       gap_hit;

   int compared   = 0;
   int mismatched = 0;

   neopix_byte_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .dout       (dout),
      .busy       (busy),
      .overflow   (overflow),
      .gap_hit    (gap_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         if (mismatched <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus "cycles left in the current byte frame" and
   // "cycles left in the latch"; line level comes from bit position arithmetic.
   logic [7:0] mq[$];
   logic [7:0] cur;
   int         rem;
   int         gap_rem;
   int         m_p;
   bit         m_idle, m_pop, m_full, m_acc;
   bit         m_dout, m_busy, m_ovf, m_gh;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         rem = 0; gap_rem = 0; cur = 8'h00;
         m_dout = 0; m_busy = 0; m_ovf = 0; m_gh = 0;
      end else begin
         m_idle = (rem == 0) && (gap_rem == 0);
         m_pop  = (mq.size() > 0) && (m_idle || rem == 1);
         m_full = (mq.size() == DEPTH);
         m_acc  = data_valid && (!m_full || m_pop);
         if (data_valid && !m_acc) m_ovf = 1;
         if (m_acc && gap_rem > 0) m_gh = 1;
         if (rem > 0) begin
            m_p    = BYTE_CYC - rem;
            m_dout = (m_p % TBIT) < (cur[7 - m_p / TBIT] ? T1H : T0H);
         end else begin
            m_dout = 0;
         end
         if (m_pop) begin
            cur = mq.pop_front();
            rem = BYTE_CYC;
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) gap_rem = RST_CYC;
         end else if (gap_rem > 0) begin
            gap_rem--;
         end
         if (m_acc) mq.push_back(data_in);
         m_busy = (rem > 0) || (gap_rem > 0) || (mq.size() > 0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_dout",     int'(dout),     int'(m_dout));
         chk("cyc_busy",     int'(busy),     int'(m_busy));
         chk("cyc_overflow", int'(overflow), int'(m_ovf));
         chk("cyc_gap_hit",  int'(gap_hit),  int'(m_gh));
      end
   end

   // Rising-edge counter on the line, used for byte counts.
   int   rise_cnt = 0;
   logic mon_prev = 1'b0;
   always @(negedge clk) begin
      if (dout && !mon_prev) rise_cnt++;
      mon_prev = dout;
   end

   int rises[$];
   int widths[$];
   int fall_t;

   task automatic send(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin done = 1; break; end
         @(negedge clk);
      end
      if (!done) begin
         compared++; mismatched++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
      end
   endtask

   // Record rise times and high widths (cycles from t0 = write edge of first byte) until busy drops.
   task automatic capture(input int t0, input int budget);
      logic prev;
      prev = 1'b0;
      rises.delete(); widths.delete(); fall_t = -1;
      for (int t = t0; t < t0 + budget; t++) begin
         if (dout && !prev) rises.push_back(t);
         if (!dout && prev) widths.push_back(t - rises[rises.size()-1]);
         prev = dout;
         if (!busy) begin fall_t = t; break; end
         @(negedge clk);
      end
      if (fall_t < 0) begin
         compared++; mismatched++;
         $display("FAIL capture: busy still 1 after %0d cycles, expected 0", budget);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   int exp_a5[8] = '{40, 20, 40, 20, 20, 40, 20, 40};
   int exp_c3[8] = '{40, 40, 20, 20, 20, 20, 40, 40};
   int base;
   int ew;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_dout",     int'(dout),     0);
      chk("rst_busy",     int'(busy),     0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_gap_hit",  int'(gap_hit),  0);
      rst = 1'b0;
      @(negedge clk);

      // 1: single 0xA5
      send(8'hA5);
      capture(0, 6000);
      chk("t1_nrise", rises.size(), 8);
      chk("t1_first_rise", at(rises, 0), 2);
      for (int i = 0; i < 8; i++) chk($sformatf("t1_width%0d", i), at(widths, i), exp_a5[i]);
      for (int i = 1; i < 8; i++) chk($sformatf("t1_period%0d", i), at(rises, i) - at(rises, i-1), TBIT);
      chk("t1_busy_len", fall_t, 1 + BYTE_CYC + RST_CYC);
      chk("t1_overflow", int'(overflow), 0);
      chk("t1_gap_hit",  int'(gap_hit),  0);

      // 2: 0xFF,0x00,0x80 on consecutive cycles
      do_reset();
      send(8'hFF); send(8'h00); send(8'h80);
      capture(2, 9000);
      chk("t2_nrise", rises.size(), 24);
      for (int i = 0; i < 24; i++) begin
         ew = (i < 8 || i == 16) ? T1H : T0H;
         chk($sformatf("t2_width%0d", i), at(widths, i), ew);
      end
      for (int i = 1; i < 24; i++) chk($sformatf("t2_period%0d", i), at(rises, i) - at(rises, i-1), TBIT);
      chk("t2_busy_len", fall_t, 1 + 3 * BYTE_CYC + RST_CYC);

      // 3: 20-byte burst from IDLE
      do_reset();
      base = rise_cnt;
      for (int i = 0; i < 20; i++) send(8'($urandom));
      wait_idle(16000);
      chk("t3_bits",     rise_cnt - base, 17 * 8);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_gap_hit",  int'(gap_hit),  0);

      // 4: byte written at cycle 1000 of the latch
      do_reset();
      send(8'h3C);
      repeat (BYTE_CYC + 1000) @(negedge clk);
      send(8'hC3);
      chk("t4_gap_hit", int'(gap_hit), 1);
      capture(BYTE_CYC + 1001, 9000);
      chk("t4_nrise", rises.size(), 8);
      chk("t4_second_first_rise", at(rises, 0), 1 + BYTE_CYC + RST_CYC + 2);
      for (int i = 0; i < 8; i++) chk($sformatf("t4_width%0d", i), at(widths, i), exp_c3[i]);
      chk("t4_busy_len", fall_t, 2 * (1 + BYTE_CYC + RST_CYC));
      chk("t4_overflow", int'(overflow), 0);

      // 6: write while full on the byte-boundary pop edge
      do_reset();
      base = rise_cnt;
      for (int i = 0; i < 17; i++) send(8'($urandom));
      repeat (BYTE_CYC - 16) @(negedge clk);
      send(8'h81);
      chk("t6_overflow_at_boundary", int'(overflow), 0);
      wait_idle(16000);
      chk("t6_bits",     rise_cnt - base, 18 * 8);
      chk("t6_overflow", int'(overflow), 0);

      // 5: reset mid '1' bit with bytes queued
      do_reset();
      for (int i = 0; i < 4; i++) send(8'hFF);
      repeat (TBIT + 28) @(negedge clk);
      chk("t5_pre_rst_dout", int'(dout), 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_dout",     int'(dout),     0);
      chk("t5_rst_busy",     int'(busy),     0);
      chk("t5_rst_overflow", int'(overflow), 0);
      chk("t5_rst_gap_hit",  int'(gap_hit),  0);
      @(negedge clk);
      rst = 1'b0;
      base = rise_cnt;
      repeat (600) @(negedge clk);
      chk("t5_silent_bits", rise_cnt - base, 0);
      chk("t5_silent_busy", int'(busy), 0);
      send(8'h5A);
      wait_idle(5000);
      chk("t5_new_bits", rise_cnt - base, 8);

      // Randomised traffic: sparse bytes, occasional bursts, some landing in the latch
      for (int r = 0; r < 2; r++) begin
         do_reset();
         for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 450)) @(negedge clk);
            send(8'($urandom));
         end
         wait_idle(20000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
